// File: rtl/serial_accumulator.sv
// -----------------------------------------------------------------------------
// serial_accumulator
//
// Bit-serial accumulator fed LSB first by the adder B-input stream. The
// accumulator word recirculates through a WIDTH-bit shift register, one digit
// per clock. A free-running digit counter frames the words. The mode for a
// word is captured from (clr, add_en) on the last digit of the previous word.
// The modes are:
//   HOLD  (0,0) : recirculate unchanged
//   ADD   (0,1) : acc + adder_b stream
//   CLEAR (1,0) : acc := 0
//   LOAD  (1,1) : acc := adder_b stream
// A sticky two's-complement overflow flag is kept. A parallel snapshot of
// each finished word is published on acc_word.
//
// Parameters:
//   WIDTH      bits per word / digit positions per word cycle (4..72)
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   adder_b    in   serial operand bit for the current digit
//   add_en     in   add request, sampled on the last digit of a word
//   clr        in   clear request, sampled on the last digit of a word
//   acc_out    out  stored accumulator bit for the current digit
//   word_start out  high while the digit counter is 0
//   word_done  out  one-cycle pulse after a non-HOLD word completes
//   acc_word   out  parallel copy of the accumulator, updated once per word
//   overflow   out  sticky two's-complement overflow flag
// -----------------------------------------------------------------------------
module serial_accumulator #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adder_b,
    input  logic             add_en,
    input  logic             clr,
    output logic             acc_out,
    output logic             word_start,
    output logic             word_done,
    output logic [WIDTH-1:0] acc_word,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Encoding matches {clr, add_en} so the request can be captured directly.
    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        ADD   = 2'b01,
        CLEAR = 2'b10,
        LOAD  = 2'b11
    } mode_t;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dl;
    logic             carry;
    mode_t            mode;

    logic last;
    logic op_a;
    logic op_b;
    logic new_bit;
    logic carry_nxt;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    always_comb begin
        last = (cnt == LAST);
        // Masked operands.
        // The stored word takes part only in HOLD and ADD.
        // The serial stream takes part only in ADD and LOAD.
        op_a = ((mode == HOLD) || (mode == ADD)) ? dl[0] : 1'b0;
        op_b = ((mode == ADD) || (mode == LOAD)) ? adder_b : 1'b0;
        // In HOLD the carry is always 0, so this reduces to recirculation.
        // In CLEAR all three terms are 0.
        new_bit   = op_a ^ op_b ^ carry;
        carry_nxt = maj(op_a, op_b, carry);
    end

    assign acc_out    = dl[0];
    assign word_start = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dl        <= '0;
            carry     <= 1'b0;
            mode      <= HOLD;
            acc_word  <= '0;
            overflow  <= 1'b0;
            word_done <= 1'b0;
        end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            dl  <= {new_bit, dl[WIDTH-1:1]};
            // Killing the carry at the word boundary drops the carry out of
            // the sign digit. It also gives digit 0 a zero carry-in.
            carry     <= last ? 1'b0 : carry_nxt;
            word_done <= last && (mode != HOLD);

            if (last) begin
                mode     <= mode_t'({clr, add_en});
                acc_word <= {new_bit, dl[WIDTH-1:1]};
            end

            // Signed overflow: both operands share a sign but the sum does not.
            // The clear at digit 0 and the set at the last digit cannot
            // coincide because WIDTH >= 4.
            if (last && ((mode == ADD) || (mode == LOAD)) &&
                (op_a == op_b) && (new_bit != op_a)) begin
                overflow <= 1'b1;
            end else if ((cnt == '0) && ((mode == CLEAR) || (mode == LOAD))) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_accumulator.sv
// -----------------------------------------------------------------------------
// tb_serial_accumulator
//
// Directed bench for serial_accumulator with WIDTH = 8.
// A word-level arithmetic model follows the accumulator value, the mode, the
// overflow flag and the word_done pulse. A compare process checks every DUT
// output against that model on each cycle. Literal expectations at key points
// pin the model itself.
// -----------------------------------------------------------------------------
module tb_serial_accumulator;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         adder_b = 1'b0;
    logic         add_en = 1'b0;
    logic         clr = 1'b0;
    logic         acc_out;
    logic         word_start;
    logic         word_done;
    logic [W-1:0] acc_word;
    logic         overflow;

    serial_accumulator #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .adder_b    (adder_b),
        .add_en     (add_en),
        .clr        (clr),
        .acc_out    (acc_out),
        .word_start (word_start),
        .word_done  (word_done),
        .acc_word   (acc_word),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Word-level model state.
    int           mcnt = 0;
    logic [W-1:0] cur = '0;          // word currently circulating
    logic [1:0]   mmode = 2'b00;     // {clr, add_en} captured for this word
    logic [W-1:0] word_opnd = '0;    // operand streamed during this word
    logic [W-1:0] opnd_next = '0;    // operand for the next word
    logic         mov = 1'b0;
    logic         mdone = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [W-1:0] res;
        logic [W-1:0] av;
        if (rst) begin
            mcnt  = 0;
            cur   = '0;
            mmode = 2'b00;
            mov   = 1'b0;
            mdone = 1'b0;
        end else if (mcnt == W - 1) begin
            case (mmode)
                2'b00:   res = cur;
                2'b01:   res = cur + word_opnd;
                2'b10:   res = '0;
                default: res = word_opnd;
            endcase
            av = (mmode == 2'b01) ? cur : '0;
            if (mmode[1]) mov = 1'b0;
            if (mmode[0] && (av[W-1] == word_opnd[W-1]) && (res[W-1] != av[W-1]))
                mov = 1'b1;
            mdone     = (mmode != 2'b00);
            cur       = res;
            mmode     = {clr, add_en};
            word_opnd = opnd_next;
            mcnt      = 0;
        end else begin
            mcnt++;
            mdone = 1'b0;
        end
    end

    // The overflow flag drops one cycle into a CLEAR or LOAD word.
    always @(negedge clk) begin
        if (chk_en) begin
            check("acc_out",    acc_out,    cur[mcnt]);
            check("word_start", word_start, (mcnt == 0));
            check("acc_word",   acc_word,   cur);
            check("word_done",  word_done,  mdone);
            check("overflow",   overflow,   (mcnt != 0 && mmode[1]) ? 1'b0 : mov);
        end
    end

    task automatic tick();
        @(negedge clk);
        adder_b = word_opnd[mcnt];
    endtask

    // Issues the same request on n consecutive word boundaries.
    // The task returns at digit 0 of the word that performs the last request.
    task automatic request(input logic c, input logic a, input logic [W-1:0] op, input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            while (mcnt != W - 1 && guard < 4 * W) begin
                tick();
                guard++;
            end
            if (mcnt != W - 1) begin
                fails++;
                tests++;
                $display("FAIL request_timeout: got cnt %0d, expected %0d", mcnt, W - 1);
            end
            clr       = c;
            add_en    = a;
            opnd_next = op;
            tick();
            clr    = 1'b0;
            add_en = 1'b0;
        end
    endtask

    task automatic next_word_start();
        int guard = 0;
        tick();
        while (mcnt != 0 && guard < 4 * W) begin
            tick();
            guard++;
        end
        if (mcnt != 0) begin
            fails++;
            tests++;
            $display("FAIL word_timeout: got cnt %0d, expected 0", mcnt);
        end
    endtask

    initial begin
        logic [W-1:0] pat;
        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        check("rst_acc_word",   acc_word,   8'h00);
        check("rst_overflow",   overflow,   1'b0);
        check("rst_word_done",  word_done,  1'b0);
        check("rst_word_start", word_start, 1'b1);
        check("rst_acc_out",    acc_out,    1'b0);
        rst = 1'b0;

        // LOAD 5, then watch it recirculate serially
        request(1'b1, 1'b1, 8'h05, 1);
        next_word_start();
        check("load5_word", acc_word, 8'h05);
        check("load5_done", word_done, 1'b1);
        check("load5_ovf",  overflow, 1'b0);
        pat = 8'b0000_0101;
        for (int d = 0; d < W; d++) begin
            check("load5_serial", acc_out, pat[d]);
            tick();
        end

        // ADD 3 -> 0x08, then ADD 0xFD (-3) -> 0x05
        request(1'b0, 1'b1, 8'h03, 1);
        next_word_start();
        check("add3_word", acc_word, 8'h08);
        request(1'b0, 1'b1, 8'hFD, 1);
        next_word_start();
        check("addm3_word", acc_word, 8'h05);
        check("addm3_ovf",  overflow, 1'b0);

        // LOAD 0x7F, ADD 1 -> 0x80 with overflow; it holds, then CLEAR
        request(1'b1, 1'b1, 8'h7F, 1);
        next_word_start();
        check("load7f_word", acc_word, 8'h7F);
        request(1'b0, 1'b1, 8'h01, 1);
        next_word_start();
        check("ovf_word", acc_word, 8'h80);
        check("ovf_set",  overflow, 1'b1);
        pat = 8'h80;
        for (int w = 0; w < 4; w++) begin
            for (int d = 0; d < W; d++) begin
                check("hold_serial", acc_out, pat[d]);
                check("hold_ovf",    overflow, 1'b1);
                tick();
            end
        end
        request(1'b1, 1'b0, 8'h00, 1);
        next_word_start();
        check("clear_word", acc_word, 8'h00);
        check("clear_ovf",  overflow, 1'b0);
        check("clear_done", word_done, 1'b1);

        // Pulse add_en away from the word boundary: it must be ignored
        opnd_next = 8'h33;
        while (mcnt != 3) tick();
        add_en = 1'b1;
        tick();
        add_en = 1'b0;
        next_word_start();
        next_word_start();
        check("midpulse_word", acc_word, 8'h00);
        check("midpulse_done", word_done, 1'b0);

        // LOAD 0x10, then hold ADD 1 over three boundaries -> 0x13
        request(1'b1, 1'b1, 8'h10, 1);
        request(1'b0, 1'b1, 8'h01, 3);
        next_word_start();
        check("b2b_word", acc_word, 8'h13);
        check("b2b_done", word_done, 1'b1);

        // Reset at digit 4 of an ADD word
        request(1'b1, 1'b1, 8'h5A, 1);
        next_word_start();
        check("load5a_word", acc_word, 8'h5A);
        request(1'b0, 1'b1, 8'h11, 1);
        while (mcnt != 4) tick();
        rst = 1'b1;
        tick();
        check("midrst_word",  acc_word,   8'h00);
        check("midrst_start", word_start, 1'b1);
        check("midrst_done",  word_done,  1'b0);
        check("midrst_out",   acc_out,    1'b0);
        check("midrst_ovf",   overflow,   1'b0);
        rst = 1'b0;

        // Counter wrap with no requests
        for (int i = 0; i < 3 * W + 2; i++) begin
            check("wrap_start", word_start, ((i % W) == 0));
            check("wrap_word",  acc_word,   8'h00);
            if (i == W) check("wrap_no_done", word_done, 1'b0);
            tick();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_accumulator.md
# serial_accumulator

Bit-serial accumulator at the receiving end of the adder B-input stream: it takes the serial operand produced by the complementer/collater unit and adds it, LSB first, into a recirculating accumulator word. It owns the digit-position counter for its word and keeps a carry flip-flop. It also detects two's-complement overflow and presents the accumulator both serially (for recirculation and downstream units) and as a parallel snapshot for the bench and the display logic.

## Interface
- `WIDTH`, default 36: bits per accumulator word (digit positions per word cycle, LSB = digit 0, sign = digit WIDTH-1); legal range 4..72.
- `clk`  in  1  pulse-interval clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `adder_b`  in  1  serial operand bit for the current digit (already complemented/collated upstream).
- `add_en`  in  1  request: add `adder_b` stream during the next word.
- `clr`  in  1  request: discard stored accumulator content during the next word.
- `acc_out`  out  1  stored accumulator bit for the current digit.
- `word_start`  out  1  high while digit counter = 0.
- `word_done`  out  1  one-cycle pulse, the cycle after a word in which `add_en` or `clr` was in effect completes.
- `acc_word`  out  WIDTH  parallel copy of the accumulator, updated once per word.
- `overflow`  out  1  sticky two's-complement overflow flag.

## Operation
- Digit counter `cnt` runs 0..WIDTH-1, wraps to 0; free-running, never stalls.
- Storage: WIDTH-bit shift register `dl`; `acc_out` = `dl[0]`. Every cycle `dl <= {new_bit, dl[WIDTH-1:1]}`, so each bit recirculates once per word.
- Word mode latched from (`clr`, `add_en`) on the cycle `cnt == WIDTH-1`; it applies to the entire following word. Inputs on other cycles are ignored.
  - HOLD (0,0): new_bit = acc_out.
  - ADD (0,1): new_bit = acc_out ^ adder_b ^ carry.
  - CLEAR (1,0): new_bit = 0.
  - LOAD (1,1): new_bit = adder_b ^ carry (accumulator operand forced to 0).
- Carry: `carry <= maj(a, b, carry)`, where a and b are the masked operand bits of the mode. Carry is forced to 0 on the cycle `cnt == WIDTH-1`, so carry-in at digit 0 is always 0. Carry out of the sign digit is discarded (modulo 2^WIDTH arithmetic).
- `acc_word <= {new_bit, dl[WIDTH-1:1]}` on the cycle `cnt == WIDTH-1`, i.e. the complete new word.
- Overflow:
  - Clear: on the first cycle of any word in CLEAR or LOAD mode.
  - Set: at digit WIDTH-1 of an ADD or LOAD word if a == b and new_bit != a.
  - Otherwise holds its value.
- `word_done` is registered high for one cycle after `cnt == WIDTH-1` if the word's mode was not HOLD.

## Timing
- Reset values: `cnt`=0, `dl`=0, carry=0, mode=HOLD, `acc_word`=0, `overflow`=0, `word_done`=0, `acc_out`=0. `word_start`=1 in the first cycle after reset.
- Reset mid-word aborts the word immediately: no partial `acc_word` update, no `word_done`.
- Latency:
  - Request sampled at digit WIDTH-1 of word k; operation occurs in word k+1.
  - `acc_word`/`overflow`/`word_done` are visible on the first cycle of word k+2 (cnt=0).
  - The new serial bit for digit d appears on `acc_out` exactly WIDTH cycles after it is computed.
- `adder_b` is sampled in the same cycle as the matching `acc_out` digit; the upstream unit supplies it aligned to `cnt`.
- `clr` and `add_en` asserted together select LOAD; neither has priority.
- A request held across several boundaries repeats the operation every word (back-to-back words, no gap).
- `rst` has priority over all requests.

## Test plan
- Reset, then WIDTH=8, LOAD with operand 5 (bits 1,0,1,0,0,0,0,0) → `acc_word`=0x05, `word_done` pulse at next cnt=0, `overflow`=0; the next word's `acc_out` serial = 1,0,1,0,0,0,0,0.
- ADD 3 onto 0x05 → 0x08 (carry ripples through digits 0–2); then ADD 0xFD (−3) → 0x05, with the carry out of the sign digit dropped and `overflow`=0.
- LOAD 0x7F, then ADD 0x01 → `acc_word`=0x80, `overflow`=1. Next four HOLD words: `overflow` stays 1 and `acc_out` repeats 0x80. Then CLEAR → `acc_word`=0x00, `overflow`=0.
- Pulse `add_en` only at cnt=3 (not at WIDTH-1) → word treated as HOLD, no `word_done`, `acc_word` unchanged.
- Assert `rst` at cnt=4 of an ADD word → next cycle all outputs at reset values, `cnt`=0, `word_start`=1, no `word_done`.
- Counter wrap: run 3·WIDTH+2 cycles with no requests → `word_start` high exactly at cycles 0, WIDTH, 2·WIDTH, 3·WIDTH; `acc_word` constant.
